// File: rtl/pulse_meter.sv
// pulse_meter: measures the length (in clock cycles) of each complete high
// pulse on `in` and hands it to a consumer over the dav_/rfd byte handshake.
// Optional feature macro: PULSE_METER_OVF_EN adds the `ovf` saturation flag.
module pulse_meter (
  input  logic       clock,
  input  logic       reset_,
  input  logic       in,
  input  logic       rfd,
  output logic       dav_,
  output logic [7:0] num
`ifdef PULSE_METER_OVF_EN
  ,output logic      ovf
`endif
);

  typedef enum logic [2:0] {W0, W1, MEAS, HS_OUT, HS_ACK} state_t;

  state_t     state_q, state_d;
  logic [7:0] count;

  // State register
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state_q <= W0;
    else         state_q <= state_d;
  end

  // Next-state logic; W0 exists so a pulse already high is never measured
  always_comb begin
    state_d = state_q;
    case (state_q)
      W0:      if (!in) state_d = W1;
      W1:      if (in)  state_d = MEAS;
      MEAS:    if (!in) state_d = HS_OUT;
      HS_OUT:  if (!rfd) state_d = HS_ACK;
      HS_ACK:  if (rfd) state_d = W0;
      default: state_d = W0;
    endcase
  end

  // Pulse counter, result capture and dav_ handshake output
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      count <= 8'd0;
      num   <= 8'd0;
      dav_  <= 1'b1;
    end else begin
      case (state_q)
        W1:     if (in) count <= 8'd1;
        MEAS: begin
          if (in) begin
            if (count != 8'hff) count <= count + 8'd1;
          end else begin
            num  <= count;
            dav_ <= 1'b0;
          end
        end
        HS_OUT: if (!rfd) dav_ <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PULSE_METER_OVF_EN
  logic ovf_bit;

  // Overflow tracking: set when a sample arrives with the counter already full
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      ovf_bit <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_q)
        MEAS: begin
          if (in) begin
            if (count == 8'hff) ovf_bit <= 1'b1;
          end else begin
            ovf <= ovf_bit;
          end
        end
        HS_ACK: if (rfd) ovf_bit <= 1'b0;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter: the stimulus process decides from pulse
// timing whether a pulse will be measured and queues the expected result; a
// negedge monitor compares each dav_ fall against the queue.
module tb_pulse_meter;

  logic       clock = 1'b0;
  logic       reset_;
  logic       in;
  logic       rfd;
  logic       dav_;
  logic [7:0] num;
`ifdef PULSE_METER_OVF_EN
  logic       ovf;
`endif

  pulse_meter dut (
    .clock (clock),
    .reset_(reset_),
    .in    (in),
    .rfd   (rfd),
    .dav_  (dav_),
    .num   (num)
`ifdef PULSE_METER_OVF_EN
    ,.ovf  (ovf)
`endif
  );

  always #5 clock = ~clock;

  // Edge counter: value after edge k is k
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int num;
    int ovf;
    int fall;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   accept_from = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pop on each dav_ fall, check hold-stability while dav_ is low
  logic       prev_dav = 1'b1;
  logic [7:0] held;
  always @(negedge clock) begin
    if (!reset_) begin
      prev_dav = 1'b1;
    end else begin
      if (!dav_ && prev_dav) begin
        if (q.size() == 0) begin
          chk("unexpected_dav", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("num", int'(num), e.num);
          chk("fall_cycle", cyc, e.fall);
`ifdef PULSE_METER_OVF_EN
          chk("ovf", int'(ovf), e.ovf);
`endif
        end
      end else if (!dav_) begin
        chk("num_stable", int'(num), int'(held));
      end
      prev_dav = dav_;
    end
    held = num;
  end

  // Consumer side: rfd stays high h1 cycles, drops, then comes back after h2;
  // optionally a pulse of inj cycles is sent while the meter is in handshake.
  task automatic handshake(input int k, input int h1, input int h2, input int inj);
    int j, re;
    repeat (h1) tick();
    rfd = 1'b0;
    j   = cyc;
    re  = (j + 1 > k + 2) ? j + 1 : k + 2;
    while (cyc < re - 1) tick();
    @(negedge clock);
    chk("dav_low_before_rise", int'(dav_), 0);
    @(negedge clock);
    chk("dav_rise", int'(dav_), 1);
    repeat (h2) tick();
    if (inj > 0) begin
      in = 1'b1;
      repeat (inj) tick();
      in = 1'b0;
      tick();
    end
    tick();
    rfd = 1'b1;
    accept_from = cyc + 3;
  endtask

  // Reference rule: a pulse is measured iff its first high sample is on or
  // after accept_from; lengths saturate at 255, overflow means >=256 samples.
  task automatic pulse(input int len, input int idle, input bit hs,
                       input int h1, input int h2, input int inj);
    int s, k;
    exp_t e;
    repeat (idle + 1) tick();
    in = 1'b1;
    s  = cyc + 1;
    repeat (len) tick();
    in = 1'b0;
    k  = cyc;
    if (s >= accept_from) begin
      e.num  = (len > 255) ? 255 : len;
      e.ovf  = (len >= 256) ? 1 : 0;
      e.fall = k + 1;
      q.push_back(e);
      if (hs) handshake(k, h1, h2, inj);
    end else begin
      accept_from = (k + 2 > accept_from) ? k + 2 : accept_from;
    end
  endtask

  task automatic release_reset();
    reset_ = 1'b1;
    accept_from = cyc + 2;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dav"}, int'(dav_), 1);
    chk({tag, "_num"}, int'(num), 0);
`ifdef PULSE_METER_OVF_EN
    chk({tag, "_ovf"}, int'(ovf), 0);
`endif
  endtask

  initial begin
    int x, y, len, idle, h1, h2, inj;
    reset_ = 1'b0;
    in     = 1'b0;
    rfd    = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");
    release_reset();

    // Basic 5-cycle pulse, consumer waits 10 clocks before taking it
    pulse(5, 2, 1'b1, 10, 1, 0);

    // Saturation then a short pulse
    pulse(300, 2, 1'b1, 2, 1, 0);
    pulse(7, 2, 1'b1, 0, 0, 0);
    pulse(255, 2, 1'b1, 1, 2, 0);
    pulse(256, 2, 1'b1, 3, 0, 0);

    // `in` already high at reset release: that pulse is discarded
    tick();
    reset_ = 1'b0;
    in     = 1'b1;
    #1;
    check_reset_vals("reset_in_high");
    tick();
    reset_ = 1'b1;
    repeat (5) tick();
    in = 1'b0;
    accept_from = cyc + 2;
    pulse(8, 2, 1'b1, 1, 1, 0);

    // Pulse during HS_ACK is lost, next one is measured
    pulse(9, 2, 1'b1, 1, 3, 4);
    pulse(6, 2, 1'b1, 1, 1, 0);

    // Reset mid-MEAS
    repeat (3) tick();
    in = 1'b1;
    repeat (4) tick();
    #1 reset_ = 1'b0;
    #1 check_reset_vals("reset_meas");
    in = 1'b0;
    tick();
    release_reset();
    pulse(3, 2, 1'b1, 1, 1, 0);

    // Reset mid-HS_OUT
    pulse(5, 2, 1'b0, 0, 0, 0);
    repeat (2) tick();
    #1 reset_ = 1'b0;
    #1 check_reset_vals("reset_hsout");
    tick();
    release_reset();
    pulse(3, 2, 1'b1, 1, 1, 0);

    // Chained behind the max-pulse generator
    x = 9;
    y = 200;
    pulse((x > y) ? x : y, 2, 1'b1, 1, 1, 0);

    // Randomized traffic; short idles make some pulses fall in the lockout
    for (int i = 0; i < 40; i++) begin
      len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 260))
                                         : int'($urandom_range(1, 20));
      idle = $urandom_range(0, 3);
      h1   = $urandom_range(0, 5);
      h2   = $urandom_range(0, 4);
      inj  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      pulse(len, idle, 1'b1, h1, h2, inj);
    end

    repeat (5) tick();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
